// File: rtl/dff_pipe_pkg.sv
// Shared constants, the occupancy-width helper and the default occupancy type for dff_pipe.
`timescale 1ns/1ps
package dff_pipe_pkg;

  localparam int DFF_PIPE_MAX_DEPTH = 16;
  localparam int DEFAULT_WIDTH      = 8;
  localparam int DEFAULT_DEPTH      = 3;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [cnt_w(DEFAULT_DEPTH)-1:0] occ_t;

endpackage

// File: rtl/dff_pipe_stage.sv
// One elastic register slice of dff_pipe: valid bit plus data word, loaded when adv is high.
// With DFF_PIPE_TIMING_CHECK_EN defined it carries setup/hold checks that corrupt the data on violation.
`timescale 1ns/1ps
module dff_pipe_stage
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
`ifdef DFF_PIPE_TIMING_CHECK_EN
  ,
  parameter int SETUP_NS  = 2,
  parameter int HOLD_NS   = 1,
  parameter int STAGE_IDX = 0
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
  output logic             vout,
  output logic [WIDTH-1:0] dout
);

  logic             v_q, v_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Data only loads alongside a valid word so bubbles never toggle the data flops.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (flush) begin
      v_d = 1'b0;
    end else if (adv) begin
      v_d = vin;
      if (vin) begin
        d_d = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
    end else begin
      v_q <= v_d;
    end
  end

`ifdef DFF_PIPE_TIMING_CHECK_EN
  reg          notifier;
  logic        notifier_seen;
  int unsigned viol_cnt = 0;

  specify
    $setup(din, posedge clk, SETUP_NS, notifier);
    $hold(posedge clk, din, HOLD_NS, notifier);
  endspecify

  always @(notifier) begin
    viol_cnt <= viol_cnt + 1;
    $display("dff_pipe stage %0d timing violation at %0t", STAGE_IDX, $time);
  end

  // A notifier change poisons the captured word; the valid bit is left alone.
  always @(posedge clk or negedge rst_n or notifier) begin
    if (!rst_n) begin
      d_q <= RESET_VAL;
    end else if (notifier !== notifier_seen) begin
      d_q           <= 'x;
      notifier_seen <= notifier;
    end else begin
      d_q <= d_d;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= RESET_VAL;
    end else begin
      d_q <= d_d;
    end
  end
`endif

  assign vout = v_q;
  assign dout = d_q;

endmodule

// File: rtl/dff_pipe.sv
// WIDTH x DEPTH elastic register pipeline with valid/ready flow control, flush and occupancy count.
// Define DFF_PIPE_TIMING_CHECK_EN to enable per-stage setup/hold timing checks.
`timescale 1ns/1ps
module dff_pipe
  import dff_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int SETUP_NS = 2,
  parameter int HOLD_NS  = 1,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

  if (DEPTH < 1 || DEPTH > DFF_PIPE_MAX_DEPTH || SETUP_NS < 0 || HOLD_NS < 0) begin : g_bad_cfg
    $error("dff_pipe: DEPTH must be 1..16 and timing limits non-negative");
  end

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [WIDTH-1:0] d [DEPTH];

  // Stage i stalls only when it and every stage ahead of it are full and the
  // output is blocked; this is the ready chain with the recursion unrolled.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    adv      = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      all_full = all_full & v[i];
      adv[i]   = out_ready | ~all_full;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             vin;
    logic [WIDTH-1:0] din;

    if (i == 0) begin : g_head
      assign vin = in_valid;
      assign din = in_data;
    end else begin : g_body
      assign vin = v[i-1];
      assign din = d[i-1];
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
`ifdef DFF_PIPE_TIMING_CHECK_EN
      ,
      .SETUP_NS  (SETUP_NS),
      .HOLD_NS   (HOLD_NS),
      .STAGE_IDX (i)
`endif
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .adv   (adv[i]),
      .vin   (vin),
      .din   (din),
      .vout  (v[i]),
      .dout  (d[i])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];

  logic             in_xfer, out_xfer;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (in_xfer && !out_xfer) begin
      occ_d = occ_q + CNT_W'(1);
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe (WIDTH=8, DEPTH=3): directed vectors plus a queue-based reference.
`timescale 1ns/1ps
module tb_dff_pipe;
  import dff_pipe_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  occ_t             occupancy;

  int n_cmp  = 0;
  int n_fail = 0;

  dff_pipe #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .RESET_VAL (8'h00),
    .SETUP_NS  (2),
    .HOLD_NS   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] dat,
                               input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    in_valid  = v;
    in_data   = dat;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Reference: accepted words sit in a FIFO tagged with their accept cycle; the head
  // is visible once DEPTH cycles have passed, and the pipe refuses input only when
  // it holds DEPTH words while the output is blocked.
  typedef struct {
    logic [WIDTH-1:0] data;
    int               entry;
  } ent_t;

  ent_t             mq[$];
  logic [WIDTH-1:0] seen[$];
  int               cyc = 0;

  always @(negedge clk) begin
    logic exp_ov, exp_ir, in_x, out_x;
    if (!rst_n) begin
      mq.delete();
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_occupancy", occupancy, 0);
      checkOutput("rst_out_data", out_data, 0);
      checkOutput("rst_in_ready", in_ready, 1);
    end else begin
      exp_ov = (mq.size() > 0) && (cyc >= mq[0].entry + DEPTH);
      exp_ir = out_ready || (mq.size() < DEPTH);
      checkOutput("model_out_valid", out_valid, exp_ov);
      checkOutput("model_in_ready", in_ready, exp_ir);
      checkOutput("model_occupancy", occupancy, mq.size());
      if (exp_ov) checkOutput("model_out_data", out_data, mq[0].data);
      if (out_valid === 1'b1 && out_ready) seen.push_back(out_data);
      in_x  = in_valid && exp_ir;
      out_x = exp_ov && out_ready;
      if (flush) begin
        mq.delete();
      end else begin
        if (out_x) void'(mq.pop_front());
        if (in_x) mq.push_back('{in_data, cyc});
      end
    end
    cyc++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [11:0] rdy_pat;
    rdy_pat = 12'b1011_0011_1101;
    rst_n   = 1'b0;

    // Reset and startup
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("startup_out_valid", out_valid, 0);
    checkOutput("startup_occupancy", occupancy, 0);
    checkOutput("startup_out_data", out_data, 8'h00);
    checkOutput("startup_in_ready", in_ready, 1);

    // Streaming with no stall
    applyStimulus(1, 8'h11, 1, 0);
    applyStimulus(1, 8'h22, 1, 0);
    applyStimulus(1, 8'h33, 1, 0);
    applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("stream_c3_valid", out_valid, 1);
    checkOutput("stream_c3_data", out_data, 8'h11);
    checkOutput("stream_c3_occ", occupancy, 3);
    applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("stream_c4_data", out_data, 8'h22);
    applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("stream_c5_data", out_data, 8'h33);
    checkOutput("stream_c5_occ", occupancy, 1);
    applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("stream_c6_valid", out_valid, 0);
    checkOutput("stream_c6_occ", occupancy, 0);

    // Backpressure: fill, hold the fourth word upstream, then drain
    seen.delete();
    applyStimulus(1, 8'hA1, 0, 0);
    applyStimulus(1, 8'hA2, 0, 0);
    applyStimulus(1, 8'hA3, 0, 0);
    applyStimulus(1, 8'hA4, 0, 0);
    @(negedge clk);
    checkOutput("bp_full_in_ready", in_ready, 0);
    checkOutput("bp_full_occ", occupancy, 3);
    checkOutput("bp_full_data", out_data, 8'hA1);
    applyStimulus(1, 8'hA4, 0, 0);
    @(negedge clk);
    checkOutput("bp_hold_in_ready", in_ready, 0);
    checkOutput("bp_hold_data", out_data, 8'hA1);
    applyStimulus(1, 8'hA4, 1, 0);
    @(negedge clk);
    checkOutput("bp_release_in_ready", in_ready, 1);
    repeat (5) applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("bp_count", seen.size(), 4);
    if (seen.size() == 4) begin
      checkOutput("bp_order0", seen[0], 8'hA1);
      checkOutput("bp_order1", seen[1], 8'hA2);
      checkOutput("bp_order2", seen[2], 8'hA3);
      checkOutput("bp_order3", seen[3], 8'hA4);
    end

    // Flush with a simultaneous input that must be discarded
    seen.delete();
    applyStimulus(1, 8'hB1, 0, 0);
    applyStimulus(1, 8'hB2, 0, 0);
    applyStimulus(1, 8'h55, 0, 1);
    @(negedge clk);
    checkOutput("flush_pre_occ", occupancy, 2);
    applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("flush_occ", occupancy, 0);
    checkOutput("flush_out_valid", out_valid, 0);
    repeat (6) applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("flush_no_output", seen.size(), 0);

    // Mixed valid stream against an irregular out_ready pattern
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1, 8'(8'hC0 + i), rdy_pat[i], 0);
    end
    repeat (8) applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("mixed_drained_occ", occupancy, 0);

    // Asynchronous reset between clock edges while full
    applyStimulus(1, 8'hD1, 0, 0);
    applyStimulus(1, 8'hD2, 0, 0);
    applyStimulus(1, 8'hD3, 0, 0);
    applyStimulus(0, 8'h00, 0, 0);
    #1;
    checkOutput("async_pre_occ", occupancy, 3);
    checkOutput("async_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("async_out_valid", out_valid, 0);
    checkOutput("async_occ", occupancy, 0);
    checkOutput("async_in_ready", in_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) applyStimulus(0, 8'h00, 1, 0);
    @(negedge clk);
    checkOutput("async_after_valid", out_valid, 0);
    checkOutput("async_after_occ", occupancy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
